// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the small AXI4-Lite register blocks in the PL.
//   RESP_*      : AXI response codes
//   *_OFS       : byte offsets of the LED register block map
//   reg_slot_t  : decoded register slot (SLOT_NONE = unmapped)
//   rd_state_t  : read channel states
//   apply_wstrb : merges write data into an old value under byte strobes
// ---------------------------------------------------------------------------
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int ID_OFS      = 'h00;
   localparam int LED_OFS     = 'h04;
   localparam int SCRATCH_OFS = 'h08;
   localparam int BTN_OFS     = 'h0C;

   typedef enum logic [2:0] {
      SLOT_ID,
      SLOT_LED,
      SLOT_SCRATCH,
      SLOT_BTN,
      SLOT_NONE
   } reg_slot_t;

   typedef enum logic {
      RD_IDLE,
      RD_RESP
   } rd_state_t;

   // Byte i of the result comes from new_value when strb[i] is set,
   // otherwise the old byte is kept.
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_value,
                                               input logic [31:0] new_value,
                                               input logic [3:0]  strb);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[i*8 +: 8] = strb[i] ? new_value[i*8 +: 8] : old_value[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axi_lite_led_regs_if.sv
// ---------------------------------------------------------------------------
// axi_lite_led_regs_if
// AXI4-Lite bus bundle between the PS general-purpose master and the LED
// register block.
//   master modport : initiator side (drives addresses, write data, ready for
//                    responses)
//   slave modport  : responder side (drives address/data ready, B and R
//                    responses)
// Parameter ADDR_WIDTH sets the width of s_axi_awaddr / s_axi_araddr.
// ---------------------------------------------------------------------------
interface axi_lite_led_regs_if #(
   parameter int ADDR_WIDTH = 5
);

   logic [ADDR_WIDTH-1:0] s_axi_awaddr;
   logic                  s_axi_awvalid;
   logic                  s_axi_awready;

   logic [31:0]           s_axi_wdata;
   logic [3:0]            s_axi_wstrb;
   logic                  s_axi_wvalid;
   logic                  s_axi_wready;

   logic [1:0]            s_axi_bresp;
   logic                  s_axi_bvalid;
   logic                  s_axi_bready;

   logic [ADDR_WIDTH-1:0] s_axi_araddr;
   logic                  s_axi_arvalid;
   logic                  s_axi_arready;

   logic [31:0]           s_axi_rdata;
   logic [1:0]            s_axi_rresp;
   logic                  s_axi_rvalid;
   logic                  s_axi_rready;

   modport master (
      output s_axi_awaddr, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bresp, s_axi_bvalid,
      output s_axi_bready,
      output s_axi_araddr, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      output s_axi_rready
   );

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bresp, s_axi_bvalid,
      input  s_axi_bready,
      input  s_axi_araddr, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      input  s_axi_rready
   );

endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for asynchronous level inputs (buttons, switches).
// Each bit is synchronized independently; no multi-bit coherency is implied.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both stages clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk edges after d
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/axi_lite_led_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_led_regs
// AXI4-Lite responder exposing a small register file to the PS:
//   0x00 ID (RO), 0x04 LED (RW), 0x08 SCRATCH (RW), 0x0C BTN (RO),
//   0x10-0x1C unmapped (SLVERR, reads return 0).
// Ports:
//   sys_clock  : sole clock, rising edge
//   sys_resetn : asynchronous active-low reset
//   s_axi      : AXI4-Lite slave modport (AW, W, B, AR, R channels)
//   led        : registered LED drive (low LED_WIDTH bits of LED register)
//   btn        : asynchronous button inputs, synchronized before use
// ---------------------------------------------------------------------------
module axi_lite_led_regs
   import axi_lite_pkg::*;
#(
   parameter int          ADDR_WIDTH = 5,
   parameter logic [31:0] ID_VALUE   = 32'h4152_5459,
   parameter int          LED_WIDTH  = 4,
   parameter int          BTN_WIDTH  = 4
) (
   input  logic                 sys_clock,
   input  logic                 sys_resetn,
   axi_lite_led_regs_if.slave   s_axi,
   output logic [LED_WIDTH-1:0] led,
   input  logic [BTN_WIDTH-1:0] btn
);

   // Shared register storage
   logic [LED_WIDTH-1:0] led_q;
   logic [31:0]          scratch_q;
   logic [BTN_WIDTH-1:0] btn_sync;

   // Write channel state
   logic                  aw_full;
   logic                  w_full;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [31:0]           w_data_q;
   logic [3:0]            w_strb_q;
   logic                  awready_q;
   logic                  wready_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  b_hs;
   logic                  wr_commit;
   logic                  aw_full_next;
   logic                  w_full_next;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [31:0]           wr_data;
   logic [3:0]            wr_strb;
   reg_slot_t             wr_slot;

   // Read channel state
   rd_state_t             rd_state;
   rd_state_t             rd_state_next;
   logic                  arready_q;
   logic [31:0]           rdata_q;
   logic [1:0]            rresp_q;
   logic                  ar_hs;
   logic                  r_hs;
   reg_slot_t             rd_slot;
   logic [31:0]           rd_value;
   logic [1:0]            rd_resp;

   // Maps a byte address onto a register slot; the low two address bits
   // are masked off so any byte within a word hits that word.
   function automatic reg_slot_t decode_slot(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] word_base;
      word_base = addr & ~ADDR_WIDTH'(3);
      if (word_base == ADDR_WIDTH'(ID_OFS))      return SLOT_ID;
      if (word_base == ADDR_WIDTH'(LED_OFS))     return SLOT_LED;
      if (word_base == ADDR_WIDTH'(SCRATCH_OFS)) return SLOT_SCRATCH;
      if (word_base == ADDR_WIDTH'(BTN_OFS))     return SLOT_BTN;
      return SLOT_NONE;
   endfunction

   sync_2ff #(
      .WIDTH (BTN_WIDTH)
   ) u_btn_sync (
      .clk   (sys_clock),
      .rst_n (sys_resetn),
      .d     (btn),
      .q     (btn_sync)
   );

   // -----------------------------------------------------------------------
   // Write channel
   // AW and W each land in a one-entry holding register. The write commits
   // in the edge where both are available (held or arriving right now) and
   // no B is outstanding. Entries stay held until the B handshake so the
   // ready signals backpressure the next write while a response is pending.
   // -----------------------------------------------------------------------
   always_comb begin
      aw_hs        = s_axi.s_axi_awvalid & awready_q;
      w_hs         = s_axi.s_axi_wvalid & wready_q;
      b_hs         = bvalid_q & s_axi.s_axi_bready;
      wr_addr      = aw_full ? aw_addr_q : s_axi.s_axi_awaddr;
      wr_data      = w_full ? w_data_q : s_axi.s_axi_wdata;
      wr_strb      = w_full ? w_strb_q : s_axi.s_axi_wstrb;
      wr_commit    = (aw_full | aw_hs) & (w_full | w_hs) & ~bvalid_q;
      wr_slot      = decode_slot(wr_addr);
      aw_full_next = (aw_full | aw_hs) & ~b_hs;
      w_full_next  = (w_full | w_hs) & ~b_hs;
   end

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         led_q     <= '0;
         scratch_q <= '0;
      end else begin
         aw_full   <= aw_full_next;
         w_full    <= w_full_next;
         awready_q <= ~aw_full_next;
         wready_q  <= ~w_full_next;
         if (aw_hs) begin
            aw_addr_q <= s_axi.s_axi_awaddr;
         end
         if (w_hs) begin
            w_data_q <= s_axi.s_axi_wdata;
            w_strb_q <= s_axi.s_axi_wstrb;
         end
         if (wr_commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= (wr_slot == SLOT_NONE) ? RESP_SLVERR : RESP_OKAY;
            case (wr_slot)
               SLOT_LED:     led_q     <= LED_WIDTH'(apply_wstrb(32'(led_q), wr_data, wr_strb));
               SLOT_SCRATCH: scratch_q <= apply_wstrb(scratch_q, wr_data, wr_strb);
               default:      ;
            endcase
         end else if (b_hs) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   // -----------------------------------------------------------------------
   // Read channel: next state, read mux and response code
   // The mux samples the register storage as it stands before this edge,
   // so a read racing a write to the same register sees the old value.
   // -----------------------------------------------------------------------
   always_comb begin
      ar_hs         = s_axi.s_axi_arvalid & arready_q;
      r_hs          = (rd_state == RD_RESP) & s_axi.s_axi_rready;
      rd_state_next = rd_state;
      case (rd_state)
         RD_IDLE: if (ar_hs) rd_state_next = RD_RESP;
         RD_RESP: if (r_hs)  rd_state_next = RD_IDLE;
         default:            rd_state_next = RD_IDLE;
      endcase

      rd_slot  = decode_slot(s_axi.s_axi_araddr);
      rd_value = '0;
      rd_resp  = RESP_OKAY;
      case (rd_slot)
         SLOT_ID:      rd_value = ID_VALUE;
         SLOT_LED:     rd_value = 32'(led_q);
         SLOT_SCRATCH: rd_value = scratch_q;
         SLOT_BTN:     rd_value = 32'(btn_sync);
         default:      rd_resp  = RESP_SLVERR;
      endcase
   end

   // Read channel registers. arready follows the next state so it is
   // already low in the cycle rvalid is high.
   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         rd_state  <= RD_IDLE;
         arready_q <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         rd_state  <= rd_state_next;
         arready_q <= (rd_state_next == RD_IDLE);
         if (ar_hs) begin
            rdata_q <= rd_value;
            rresp_q <= rd_resp;
         end
      end
   end

   assign s_axi.s_axi_awready = awready_q;
   assign s_axi.s_axi_wready  = wready_q;
   assign s_axi.s_axi_bvalid  = bvalid_q;
   assign s_axi.s_axi_bresp   = bresp_q;
   assign s_axi.s_axi_arready = arready_q;
   assign s_axi.s_axi_rvalid  = (rd_state == RD_RESP);
   assign s_axi.s_axi_rdata   = rdata_q;
   assign s_axi.s_axi_rresp   = rresp_q;
   assign led                 = led_q;

endmodule

// File: tb/tb_axi_lite_led_regs.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_led_regs
// Directed testbench for axi_lite_led_regs: reset state, ID read, split AW/W
// write timing, byte strobes, unmapped and read-only accesses, B
// backpressure, read/write race, button synchronizer latency and
// asynchronous reset in the middle of a read.
// ---------------------------------------------------------------------------
module tb_axi_lite_led_regs;

   logic       sys_clock  = 1'b0;
   logic       sys_resetn = 1'b0;
   logic [3:0] led;
   logic [3:0] btn;

   int check_count = 0;
   int pass_count  = 0;
   int fail_count  = 0;

   logic [31:0] rd_data;
   logic [1:0]  rd_resp;
   logic [1:0]  wr_resp;

   axi_lite_led_regs_if #(.ADDR_WIDTH(5)) bus ();

   axi_lite_led_regs #(
      .ADDR_WIDTH (5),
      .ID_VALUE   (32'h4152_5459),
      .LED_WIDTH  (4),
      .BTN_WIDTH  (4)
   ) dut (
      .sys_clock  (sys_clock),
      .sys_resetn (sys_resetn),
      .s_axi      (bus),
      .led        (led),
      .btn        (btn)
   );

   always #5 sys_clock = ~sys_clock;

   // Absolute time limit in case the DUT wedges somewhere unexpected
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one
   task automatic step(input int n);
      repeat (n) @(posedge sys_clock);
      #1;
   endtask

   // Full write: AW and W presented together, then B accepted at once
   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      logic aw_done, w_done, aw_now, w_now;
      int   guard;
      bus.s_axi_awaddr  = addr;
      bus.s_axi_awvalid = 1'b1;
      bus.s_axi_wdata   = data;
      bus.s_axi_wstrb   = strb;
      bus.s_axi_wvalid  = 1'b1;
      aw_done = 1'b0;
      w_done  = 1'b0;
      guard   = 0;
      while (!(aw_done && w_done) && guard < 20) begin
         aw_now = bus.s_axi_awvalid & bus.s_axi_awready;
         w_now  = bus.s_axi_wvalid & bus.s_axi_wready;
         step(1);
         if (aw_now) begin aw_done = 1'b1; bus.s_axi_awvalid = 1'b0; end
         if (w_now)  begin w_done  = 1'b1; bus.s_axi_wvalid  = 1'b0; end
         guard++;
      end
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid  = 1'b0;
      guard = 0;
      while (!bus.s_axi_bvalid && guard < 20) begin
         step(1);
         guard++;
      end
      check_output("write_bvalid", {31'b0, bus.s_axi_bvalid}, 32'd1);
      resp = bus.s_axi_bresp;
      bus.s_axi_bready = 1'b1;
      step(1);
      bus.s_axi_bready = 1'b0;
   endtask

   // Full read; rvalid must be high right after the AR handshake edge
   task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      int guard;
      bus.s_axi_araddr  = addr;
      bus.s_axi_arvalid = 1'b1;
      guard = 0;
      while (!bus.s_axi_arready && guard < 20) begin
         step(1);
         guard++;
      end
      step(1);
      bus.s_axi_arvalid = 1'b0;
      check_output("read_rvalid_latency", {31'b0, bus.s_axi_rvalid}, 32'd1);
      data = bus.s_axi_rdata;
      resp = bus.s_axi_rresp;
      bus.s_axi_rready = 1'b1;
      step(1);
      bus.s_axi_rready = 1'b0;
   endtask

   initial begin
      bus.s_axi_awaddr  = '0;
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata   = '0;
      bus.s_axi_wstrb   = '0;
      bus.s_axi_wvalid  = 1'b0;
      bus.s_axi_bready  = 1'b0;
      bus.s_axi_araddr  = '0;
      bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready  = 1'b0;
      btn               = 4'b0000;

      // Reset state
      step(2);
      check_output("reset_handshake_outs",
                   {27'b0, bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready,
                    bus.s_axi_bvalid, bus.s_axi_rvalid}, 32'd0);
      check_output("reset_resps", {28'b0, bus.s_axi_bresp, bus.s_axi_rresp}, 32'd0);
      check_output("reset_rdata", bus.s_axi_rdata, 32'd0);
      check_output("reset_led", {28'b0, led}, 32'd0);
      sys_resetn = 1'b1;
      #1;
      check_output("readies_low_before_edge",
                   {29'b0, bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 32'd0);
      step(1);
      check_output("readies_first_edge",
                   {29'b0, bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 32'd7);

      // ID read
      axi_read(5'h00, rd_data, rd_resp);
      check_output("id_rdata", rd_data, 32'h4152_5459);
      check_output("id_rresp", {30'b0, rd_resp}, 32'd0);

      // AW in cycle 0, W in cycle 3 to SCRATCH; bvalid must appear in cycle 4
      bus.s_axi_awaddr  = 5'h08;
      bus.s_axi_awvalid = 1'b1;
      step(1);
      bus.s_axi_awvalid = 1'b0;
      check_output("aw_held_awready", {31'b0, bus.s_axi_awready}, 32'd0);
      step(2);
      check_output("split_no_early_b", {31'b0, bus.s_axi_bvalid}, 32'd0);
      bus.s_axi_wdata  = 32'hDEAD_BEEF;
      bus.s_axi_wstrb  = 4'hF;
      bus.s_axi_wvalid = 1'b1;
      step(1);
      bus.s_axi_wvalid = 1'b0;
      check_output("split_bvalid_latency", {31'b0, bus.s_axi_bvalid}, 32'd1);
      check_output("split_bresp", {30'b0, bus.s_axi_bresp}, 32'd0);
      bus.s_axi_bready = 1'b1;
      step(1);
      bus.s_axi_bready = 1'b0;
      check_output("b_done_readies",
                   {30'b0, bus.s_axi_awready, bus.s_axi_bvalid}, 32'd2);
      axi_read(5'h08, rd_data, rd_resp);
      check_output("scratch_readback", rd_data, 32'hDEAD_BEEF);

      // Byte strobe on LED register: only byte 0 (0xFA) is taken
      axi_write(5'h04, 32'hFFFF_FFFA, 4'b0001, wr_resp);
      check_output("led_wr_bresp", {30'b0, wr_resp}, 32'd0);
      check_output("led_out", {28'b0, led}, 32'hA);
      axi_read(5'h04, rd_data, rd_resp);
      check_output("led_readback", rd_data, 32'h0000_000A);

      // Unmapped write and read
      axi_write(5'h14, 32'h5555_5555, 4'hF, wr_resp);
      check_output("unmapped_wr_bresp", {30'b0, wr_resp}, 32'd2);
      axi_read(5'h1C, rd_data, rd_resp);
      check_output("unmapped_rd_rresp", {30'b0, rd_resp}, 32'd2);
      check_output("unmapped_rd_rdata", rd_data, 32'd0);
      axi_read(5'h08, rd_data, rd_resp);
      check_output("scratch_after_unmapped", rd_data, 32'hDEAD_BEEF);
      check_output("led_after_unmapped", {28'b0, led}, 32'hA);

      // Write to read-only ID: OKAY, no effect
      axi_write(5'h00, 32'h0, 4'hF, wr_resp);
      check_output("id_wr_bresp", {30'b0, wr_resp}, 32'd0);
      axi_read(5'h00, rd_data, rd_resp);
      check_output("id_unchanged", rd_data, 32'h4152_5459);

      // Zero strobe commits nothing; unaligned address hits same word
      axi_write(5'h0B, 32'h1111_1111, 4'h0, wr_resp);
      check_output("zero_strb_bresp", {30'b0, wr_resp}, 32'd0);
      axi_read(5'h09, rd_data, rd_resp);
      check_output("zero_strb_scratch", rd_data, 32'hDEAD_BEEF);

      // Backpressure: first B held, second write must wait
      bus.s_axi_awaddr  = 5'h08;
      bus.s_axi_wdata   = 32'h1234_5678;
      bus.s_axi_wstrb   = 4'hF;
      bus.s_axi_awvalid = 1'b1;
      bus.s_axi_wvalid  = 1'b1;
      step(1);
      check_output("bp_first_bvalid", {31'b0, bus.s_axi_bvalid}, 32'd1);
      bus.s_axi_awaddr  = 5'h04;
      bus.s_axi_wdata   = 32'h0000_0005;
      step(3);
      check_output("bp_readies_low", {30'b0, bus.s_axi_awready, bus.s_axi_wready}, 32'd0);
      check_output("bp_led_unchanged", {28'b0, led}, 32'hA);
      check_output("bp_bvalid_held", {31'b0, bus.s_axi_bvalid}, 32'd1);
      bus.s_axi_bready = 1'b1;
      step(1);
      bus.s_axi_bready = 1'b0;
      check_output("bp_readies_reaccept",
                   {29'b0, bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid}, 32'd6);
      step(1);
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid  = 1'b0;
      check_output("bp_second_commit_led", {28'b0, led}, 32'h5);
      check_output("bp_second_bvalid", {31'b0, bus.s_axi_bvalid}, 32'd1);
      bus.s_axi_bready = 1'b1;
      step(1);
      bus.s_axi_bready = 1'b0;
      axi_read(5'h08, rd_data, rd_resp);
      check_output("bp_first_scratch", rd_data, 32'h1234_5678);

      // Read and write of SCRATCH accepted in the same edge: old value read
      bus.s_axi_araddr  = 5'h08;
      bus.s_axi_arvalid = 1'b1;
      bus.s_axi_awaddr  = 5'h08;
      bus.s_axi_awvalid = 1'b1;
      bus.s_axi_wdata   = 32'hCAFE_0000;
      bus.s_axi_wstrb   = 4'b1100;
      bus.s_axi_wvalid  = 1'b1;
      step(1);
      bus.s_axi_arvalid = 1'b0;
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid  = 1'b0;
      check_output("race_rdata_old", bus.s_axi_rdata, 32'h1234_5678);
      check_output("race_both_valid", {30'b0, bus.s_axi_rvalid, bus.s_axi_bvalid}, 32'd3);
      bus.s_axi_rready = 1'b1;
      bus.s_axi_bready = 1'b1;
      step(1);
      bus.s_axi_rready = 1'b0;
      bus.s_axi_bready = 1'b0;
      axi_read(5'h08, rd_data, rd_resp);
      check_output("race_scratch_new", rd_data, 32'hCAFE_5678);

      // Button synchronizer: AR at edge 1 sees old value, AR at edge 3 sees new
      btn               = 4'b0110;
      bus.s_axi_araddr  = 5'h0C;
      bus.s_axi_arvalid = 1'b1;
      step(1);
      bus.s_axi_arvalid = 1'b0;
      check_output("btn_edge1_old", bus.s_axi_rdata, 32'd0);
      bus.s_axi_rready = 1'b1;
      step(1);
      bus.s_axi_rready  = 1'b0;
      bus.s_axi_arvalid = 1'b1;
      step(1);
      bus.s_axi_arvalid = 1'b0;
      check_output("btn_edge3_new", bus.s_axi_rdata, 32'h0000_0006);
      check_output("btn_rresp", {30'b0, bus.s_axi_rresp}, 32'd0);
      bus.s_axi_rready = 1'b1;
      step(1);
      bus.s_axi_rready = 1'b0;

      // Asynchronous reset while a read response is pending
      bus.s_axi_araddr  = 5'h08;
      bus.s_axi_arvalid = 1'b1;
      step(1);
      bus.s_axi_arvalid = 1'b0;
      check_output("pre_reset_rvalid", {31'b0, bus.s_axi_rvalid}, 32'd1);
      #2;
      sys_resetn = 1'b0;
      #1;
      check_output("async_reset_rvalid", {31'b0, bus.s_axi_rvalid}, 32'd0);
      check_output("async_reset_led", {28'b0, led}, 32'd0);
      check_output("async_reset_rdata", bus.s_axi_rdata, 32'd0);
      step(1);
      sys_resetn = 1'b1;
      step(1);
      axi_read(5'h08, rd_data, rd_resp);
      check_output("scratch_after_reset", rd_data, 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
